// File: rtl/io_ctrl_pkg.sv
// Shared definitions for the jcscpu I/O controller: device IDs, FSM states and status bits.
// Status byte layout is only consumed when IO_CTRL_STATUS_EN is defined.
package io_ctrl_pkg;

    localparam logic [7:0] DEV_TTY    = 8'd0;
    localparam logic [7:0] DEV_SW     = 8'd1;
    localparam logic [7:0] DEV_LED    = 8'd2;
    localparam logic [7:0] DEV_STATUS = 8'd3;

    localparam int STAT_EMPTY = 0;
    localparam int STAT_FULL  = 1;
    localparam int STAT_STALL = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        STALL = 1'b1
    } ioState_t;

endpackage

// File: rtl/io_fifo.sv
// Synchronous FIFO buffering TTY output bytes; DEPTH must be a power of two.
// A push when full is dropped unless a pop happens on the same edge.
module io_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wrPtr;
    logic [AW-1:0]    r_rdPtr;
    logic [AW:0]      r_count;
    logic             w_doPush;
    logic             w_doPop;

    assign full     = (r_count == FULL_COUNT);
    assign empty    = (r_count == '0);
    assign w_doPop  = pop & ~empty;
    assign w_doPush = push & (~full | w_doPop);
    assign dout     = empty ? '0 : r_mem[r_rdPtr];

    always_ff @(posedge CLK) begin
        if (w_doPush) begin
            r_mem[r_wrPtr] <= din;
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) r_wrPtr <= r_wrPtr + 1'b1;
            if (w_doPop)  r_rdPtr <= r_rdPtr + 1'b1;
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/io_ctrl.sv
// Sequenced I/O controller: decodes CU strobes into select/write/read, buffers TTY output and stalls when full.
// Optional build macro IO_CTRL_STATUS_EN enables the status byte on device 3.
module io_ctrl
    import io_ctrl_pkg::*;
#(
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] LED_RESET  = 8'h00
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       io_s,
    input  logic       io_e,
    input  logic       io_da,
    input  logic       io_io,
    input  logic [7:0] bus_in,
    output logic [7:0] bus_out,
    input  logic [7:0] sw_in,
    output logic [7:0] tty_data,
    output logic       tty_valid,
    input  logic       tty_ready,
    output logic [7:0] led_out,
    output logic       io_stall
);

    ioState_t   r_state;
    ioState_t   w_nextState;
    logic       r_ioSQ;
    logic [7:0] r_ioDev;
    logic [7:0] r_led;
    logic [7:0] r_hold;
    logic [7:0] r_swMeta;
    logic [7:0] r_swSync;

    logic       w_rise;
    logic       w_selEv;
    logic       w_wrEv;
    logic       w_ttyWr;
    logic       w_pop;
    logic       w_full;
    logic       w_empty;
    logic       w_fifoPush;
    logic [7:0] w_fifoDin;
    logic       w_holdLoad;
    logic       w_stall;
    logic [7:0] w_busOut;

    // Reads are level-sensitive on io_e, so only io_s needs an edge-detect copy.
    assign w_rise  = io_s & ~r_ioSQ;
    assign w_selEv = w_rise & io_da & io_io & (r_state == IDLE);
    assign w_wrEv  = w_rise & ~io_da & io_io & (r_state == IDLE);
    assign w_ttyWr = w_wrEv & (r_ioDev == DEV_TTY);
    assign w_pop   = ~w_empty & tty_ready;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_ioSQ   <= 1'b0;
            r_ioDev  <= '0;
            r_led    <= LED_RESET;
            r_hold   <= '0;
            r_swMeta <= '0;
            r_swSync <= '0;
        end else begin
            r_state  <= w_nextState;
            r_ioSQ   <= io_s;
            r_swMeta <= sw_in;
            r_swSync <= r_swMeta;
            if (w_selEv) r_ioDev <= bus_in;
            if (w_wrEv && (r_ioDev == DEV_LED)) r_led <= bus_in;
            if (w_holdLoad) r_hold <= bus_in;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_ttyWr && w_full && !w_pop) w_nextState = STALL;
            STALL:   if (w_pop) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // While stalled, the held byte refills the slot freed by the first pop.
    always_comb begin
        w_fifoPush = 1'b0;
        w_fifoDin  = bus_in;
        w_holdLoad = 1'b0;
        w_stall    = 1'b0;
        case (r_state)
            IDLE: begin
                w_fifoPush = w_ttyWr;
                w_holdLoad = w_ttyWr & w_full & ~w_pop;
            end
            STALL: begin
                w_stall    = 1'b1;
                w_fifoPush = w_pop;
                w_fifoDin  = r_hold;
            end
            default: w_stall = 1'b0;
        endcase
    end

`ifdef IO_CTRL_STATUS_EN
    logic [7:0] w_status;

    always_comb begin
        w_status             = '0;
        w_status[STAT_EMPTY] = w_empty;
        w_status[STAT_FULL]  = w_full;
        w_status[STAT_STALL] = w_stall;
    end
`endif

    always_comb begin
        w_busOut = '0;
        if (io_e && !io_da && !io_io) begin
            case (r_ioDev)
                DEV_SW:     w_busOut = r_swSync;
                DEV_LED:    w_busOut = r_led;
`ifdef IO_CTRL_STATUS_EN
                DEV_STATUS: w_busOut = w_status;
`endif
                default:    w_busOut = '0;
            endcase
        end
    end

    io_fifo #(
        .WIDTH(8),
        .DEPTH(FIFO_DEPTH)
    ) u_ttyFifo (
        .CLK  (CLK),
        .reset(reset),
        .push (w_fifoPush),
        .pop  (w_pop),
        .din  (w_fifoDin),
        .dout (tty_data),
        .full (w_full),
        .empty(w_empty)
    );

    assign tty_valid = ~w_empty;
    assign led_out   = r_led;
    assign io_stall  = w_stall;
    assign bus_out   = w_busOut;

endmodule

// File: tb/tb_io_ctrl.sv
// Directed-vector bench for io_ctrl: select/write, single-event pulses, stall on full, reads, LED/status, reset in STALL.
// Status expectation follows IO_CTRL_STATUS_EN.
module tb_io_ctrl;

    logic       CLK;
    logic       reset;
    logic       io_s;
    logic       io_e;
    logic       io_da;
    logic       io_io;
    logic [7:0] bus_in;
    logic [7:0] bus_out;
    logic [7:0] sw_in;
    logic [7:0] tty_data;
    logic       tty_valid;
    logic       tty_ready;
    logic [7:0] led_out;
    logic       io_stall;

    int         nChecks = 0;
    int         nFail = 0;
    logic [7:0] drained [16];
    int         drainedCount;
    logic [7:0] expStatusEmpty;

    io_ctrl #(
        .FIFO_DEPTH(4),
        .LED_RESET (8'h00)
    ) dut (
        .CLK      (CLK),
        .reset    (reset),
        .io_s     (io_s),
        .io_e     (io_e),
        .io_da    (io_da),
        .io_io    (io_io),
        .bus_in   (bus_in),
        .bus_out  (bus_out),
        .sw_in    (sw_in),
        .tty_data (tty_data),
        .tty_valid(tty_valid),
        .tty_ready(tty_ready),
        .led_out  (led_out),
        .io_stall (io_stall)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        nChecks++;
        if (observed !== expected) begin
            nFail++;
            $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h", tag, observed, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // One io_s pulse held for holdCycles clocks, then released for one clock.
    task automatic applyStimulus(input logic da, input logic io, input logic [7:0] data, input int holdCycles);
        io_da  = da;
        io_io  = io;
        bus_in = data;
        io_s   = 1'b1;
        tick(holdCycles);
        io_s   = 1'b0;
        tick(1);
    endtask

    task automatic drainFifo();
        drainedCount = 0;
        tty_ready = 1'b1;
        while (tty_valid && drainedCount < 16) begin
            drained[drainedCount] = tty_data;
            drainedCount++;
            tick(1);
        end
        tty_ready = 1'b0;
    endtask

    initial begin
`ifdef IO_CTRL_STATUS_EN
        expStatusEmpty = 8'h01;
`else
        expStatusEmpty = 8'h00;
`endif
        reset = 1'b1; io_s = 1'b0; io_e = 1'b0; io_da = 1'b0; io_io = 1'b0;
        bus_in = 8'h00; sw_in = 8'h00; tty_ready = 1'b0;
        tick(2);
        reset = 1'b0;
        checkOutput("rstBusOut", bus_out, 8'h00);
        checkOutput("rstTtyValid", {7'b0, tty_valid}, 8'h00);
        checkOutput("rstTtyData", tty_data, 8'h00);
        checkOutput("rstLed", led_out, 8'h00);
        checkOutput("rstStall", {7'b0, io_stall}, 8'h00);

        $display("[TB] select TTY and write 0x41");
        applyStimulus(1'b1, 1'b1, 8'h00, 1);
        applyStimulus(1'b0, 1'b1, 8'h41, 1);
        checkOutput("wrTtyValid", {7'b0, tty_valid}, 8'h01);
        checkOutput("wrTtyData", tty_data, 8'h41);

        $display("[TB] long pulse yields one entry");
        applyStimulus(1'b0, 1'b1, 8'h42, 20);
        drainFifo();
        checkOutput("longPulseCount", 8'(drainedCount), 8'd2);
        checkOutput("longPulse0", drained[0], 8'h41);
        checkOutput("longPulse1", drained[1], 8'h42);

        $display("[TB] stall on full");
        for (int i = 1; i <= 4; i++) applyStimulus(1'b0, 1'b1, 8'(i), 1);
        checkOutput("fullNoStall", {7'b0, io_stall}, 8'h00);
        applyStimulus(1'b0, 1'b1, 8'h05, 1);
        checkOutput("stallAfter5th", {7'b0, io_stall}, 8'h01);
        applyStimulus(1'b0, 1'b1, 8'h99, 1);
        checkOutput("stallHolds", {7'b0, io_stall}, 8'h01);
        tty_ready = 1'b1;
        tick(1);
        tty_ready = 1'b0;
        checkOutput("unstall", {7'b0, io_stall}, 8'h00);
        checkOutput("headAfterPop", tty_data, 8'h02);
        drainFifo();
        checkOutput("stallDrainCount", 8'(drainedCount), 8'd4);
        for (int i = 0; i < 4; i++) checkOutput($sformatf("stallDrain%0d", i), drained[i], 8'(i + 2));

        $display("[TB] switch read");
        applyStimulus(1'b1, 1'b1, 8'h01, 1);
        sw_in = 8'hA5;
        io_da = 1'b0; io_io = 1'b0; io_e = 1'b1;
        #1;
        checkOutput("swLat0", bus_out, 8'h00);
        tick(1);
        checkOutput("swLat1", bus_out, 8'h00);
        tick(1);
        checkOutput("swLat2", bus_out, 8'hA5);
        io_e = 1'b0;
        #1;
        checkOutput("swNoEnable", bus_out, 8'h00);

        $display("[TB] LED and status");
        applyStimulus(1'b1, 1'b1, 8'h02, 1);
        applyStimulus(1'b0, 1'b1, 8'h3C, 1);
        checkOutput("ledWrite", led_out, 8'h3C);
        io_da = 1'b0; io_io = 1'b0; io_e = 1'b1;
        #1;
        checkOutput("ledRead", bus_out, 8'h3C);
        io_e = 1'b0;
        applyStimulus(1'b1, 1'b1, 8'h03, 1);
        io_da = 1'b0; io_io = 1'b0; io_e = 1'b1;
        #1;
        checkOutput("statusEmpty", bus_out, expStatusEmpty);
        io_e = 1'b0;
        applyStimulus(1'b1, 1'b1, 8'h05, 1);
        applyStimulus(1'b0, 1'b1, 8'hFF, 1);
        checkOutput("unmappedWrLed", led_out, 8'h3C);
        checkOutput("unmappedWrTty", {7'b0, tty_valid}, 8'h00);
        io_da = 1'b0; io_io = 1'b0; io_e = 1'b1;
        #1;
        checkOutput("unmappedRead", bus_out, 8'h00);
        io_e = 1'b0;

        $display("[TB] reset while stalled");
        applyStimulus(1'b1, 1'b1, 8'h00, 1);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 8'(8'h11 + i), 1);
        checkOutput("preRstStall", {7'b0, io_stall}, 8'h01);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("asyncRstStall", {7'b0, io_stall}, 8'h00);
        checkOutput("asyncRstValid", {7'b0, tty_valid}, 8'h00);
        checkOutput("asyncRstLed", led_out, 8'h00);
        tick(1);
        reset = 1'b0;
        applyStimulus(1'b0, 1'b1, 8'h7E, 1);
        checkOutput("postRstValid", {7'b0, tty_valid}, 8'h01);
        checkOutput("postRstData", tty_data, 8'h7E);
        checkOutput("postRstStall", {7'b0, io_stall}, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule

// File: doc/io_ctrl.md
# io_ctrl

Sequenced I/O controller for the jcscpu. It replaces the combinational TTY latch at top level and decodes the CU's io_s/io_e/io_da/io_io strobes into device-select, write and read transactions. It buffers TTY output bytes in a small FIFO drained by the display side, and owns the LED output register. It stalls the CPU stepper when the TTY FIFO is full, and drives read data onto the shared wired-OR bus.

## Interface
Parameters:
- FIFO_DEPTH, 4: TTY FIFO entries; power of two, 2..16.
- LED_RESET, 8'h00: reset value of the LED register.

Ports:
- CLK  in  1  system clock; all state on posedge.
- reset  in  1  asynchronous, active-high; clears all state.
- io_s, io_e, io_da, io_io  in  1 each  CU strobes. io_da: 1 = address, 0 = data. io_io: 1 = CPU→device, 0 = device→CPU.
- bus_in  in  8  CPU bus.
- bus_out  out  8  wired-OR bus contribution; 0 unless reading.
- sw_in  in  8  raw slide switches (asynchronous).
- tty_data  out  8  FIFO head.
- tty_valid  out  1  FIFO non-empty.
- tty_ready  in  1  consumer pops on tty_valid & tty_ready.
- led_out  out  8  LED register.
- io_stall  out  1  freezes the stepper while high.

## Operation
- Device map:
  - 0 = TTY (write).
  - 1 = switches (read).
  - 2 = LED (write/read).
  - 3 = status (read).
  - All other devices: writes are ignored, reads return 0.
- CU strobes last many CLK cycles. Registered copies io_s_q and io_e_q provide rising-edge events.
  - sel_ev = io_s & ~io_s_q & io_da & io_io: io_dev <= bus_in.
  - wr_ev = io_s & ~io_s_q & ~io_da & io_io: write to io_dev.
- sw_in passes through a 2-flop synchronizer (sw_q) before use.
- Write to TTY:
  - If the FIFO is not full, or a pop occurs in the same cycle, push bus_in.
  - Otherwise latch bus_in into hold_q and enter STALL.
- Write to LED: led_out <= bus_in.
- Read, combinational: when io_e & ~io_da & ~io_io, bus_out is:
  - dev1: sw_q.
  - dev2: led_out.
  - dev3: status = {5'b0, stall, full, empty}.
  - else: 0.
  - Whenever the read condition is false, bus_out = 0.
- FSM:
  - IDLE: wr_ev to TTY with FIFO full and no pop → STALL.
  - STALL: io_stall = 1; wr_ev and sel_ev are ignored. On the first cycle a pop occurs, push hold_q and go to IDLE.
- FIFO rules:
  - Push when full with no pop is never performed.
  - Pop when empty is ignored.
  - Pointers wrap modulo FIFO_DEPTH; count is log2(FIFO_DEPTH)+1 bits.

## Timing
- Reset values:
  - bus_out 0, tty_valid 0, tty_data 0.
  - led_out LED_RESET, io_stall 0.
  - io_dev 0, FSM IDLE, FIFO empty.
  - io_s_q and io_e_q 0.
  - sw_q 0.
- Event actions take effect at the CLK edge where the rising level is first sampled. Resulting outputs are visible the next cycle.
- tty_valid rises 1 cycle after a push into an empty FIFO.
- Switch-to-bus latency is 2 cycles.
- io_stall rises the cycle after the blocked wr_ev. It falls the cycle after the unblocking pop, which is the same edge that pushes hold_q.
- Reset asserted mid-transaction, including in STALL, discards hold_q and FIFO contents immediately.

## Configuration
- IO_CTRL_STATUS_EN
  - Defined: device 3 returns the status byte.
  - Undefined: the status logic is not built and device 3 reads 0.
  - All other behaviour is unchanged either way.

## Structure
- Package/include io_ctrl_pkg:
  - Device IDs DEV_TTY = 0, DEV_SW = 1, DEV_LED = 2, DEV_STATUS = 3.
  - FSM state encodings IDLE and STALL.
  - Status bit positions.
- Sub-module io_fifo: synchronous FIFO with parameters WIDTH and DEPTH, ports push/pop/din/dout/full/empty, and async reset.
- Top-level integration: STP_bus is additionally gated by io_stall, and bus_out joins the `wor` bus.

## Test plan
- Select and write: io_s pulse with da=1, io=1, bus=0x00; then da=0, io=1, bus=0x41 → tty_valid=1 and tty_data=0x41 one cycle later.
- Single event per pulse: one io_s data pulse held for 20 CLK cycles → exactly one FIFO entry.
- Stall on full: tty_ready=0, FIFO_DEPTH=4, write 5 bytes 0x01..0x05 → io_stall=1 after the 5th. Raise tty_ready for 1 cycle → 0x01 popped, io_stall=0, FIFO holds 0x02..0x05 in order.
- Reads: select dev 1, sw_in=0xA5, read strobe (da=0, io=0, io_e=1) → bus_out=0xA5 after 2 synchronizer cycles. With io_e=0 → bus_out=0.
- LED and status: select dev 2 and write 0x3C → led_out=0x3C. Select dev 3 and read with the FIFO empty → 0x01 with IO_CTRL_STATUS_EN defined, 0x00 without.
- Reset in STALL: assert reset while io_stall=1 → io_stall=0, tty_valid=0, led_out=LED_RESET asynchronously. The next TTY write of 0x7E is accepted normally.
